// File: rtl/mem_port_arbiter.sv
// Shares one ack-based single-port memory between instruction fetch and load/store, data side first.
// Ready pulses one cycle after memAck or timeout; requesters stall by holding req until their ready.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifRData,
  output logic              ifReady,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  input  logic [1:0]        dDQM,
  output logic [DATA_W-1:0] dRData,
  output logic              dReady,
  output logic              dErr,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic [3:0]        memBE,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]     TO_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    acc_off;
  logic [1:0]    acc_size;
  logic          acc_we;

  logic [1:0]        d_off;
  logic              d_mis;
  logic [3:0]        d_be;
  logic [DATA_W-1:0] d_wd;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_val;
  logic              to_hit;
  logic              ready_busy;

  assign d_off      = dAddr[1:0];
  assign to_hit     = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
  // The ready cycle itself does not arbitrate, so a requester sees its pulse before being re-sampled.
  assign ready_busy = ifReady || dReady;

  always_comb begin
    d_be  = 4'b1111;
    d_wd  = dWData;
    d_mis = 1'b0;
    case (dDQM)
      2'b00: begin
        d_be = 4'b0001 << d_off;
        d_wd = {4{dWData[7:0]}};
      end
      2'b01: begin
        d_be  = 4'b0011 << d_off;
        d_wd  = {2{dWData[15:0]}};
        d_mis = d_off[0];
      end
      default: d_mis = (d_off != 2'b00);
    endcase
  end

  assign shifted = memRData >> {acc_off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (acc_size)
      2'b00:   load_val = {24'b0, shifted[7:0]};
      2'b01:   load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      acc_off  <= '0;
      acc_size <= '0;
      acc_we   <= 1'b0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      memBE    <= '0;
      ifReady  <= 1'b0;
      dReady   <= 1'b0;
      dErr     <= 1'b0;
      ifRData  <= '0;
      dRData   <= '0;
    end else begin
      ifReady <= 1'b0;
      dReady  <= 1'b0;
      dErr    <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (!ready_busy) begin
            if (dReq) begin
              if (d_mis) begin
                dReady <= 1'b1;
                dErr   <= 1'b1;
                dRData <= '0;
              end else begin
                state    <= DACC;
                memReq   <= 1'b1;
                memWe    <= dWe;
                memAddr  <= dAddr & WORD_MASK;
                memWData <= d_wd;
                memBE    <= d_be;
                acc_off  <= d_off;
                acc_size <= dDQM;
                acc_we   <= dWe;
              end
            end else if (ifReq) begin
              state    <= IACC;
              memReq   <= 1'b1;
              memWe    <= 1'b0;
              memAddr  <= ifAddr & WORD_MASK;
              memWData <= '0;
              memBE    <= 4'b1111;
            end
          end
        end
        IACC, DACC: begin
          // An ack arriving on the final counted cycle still completes normally.
          if (memAck || to_hit) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
            state  <= IDLE;
            if (state == IACC) begin
              ifReady <= 1'b1;
              ifRData <= memAck ? memRData : '0;
            end else begin
              dReady <= 1'b1;
              dErr   <= !memAck;
              dRData <= (memAck && !acc_we) ? load_val : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
